// File: rtl/ioarb_pkg.sv
// Shared types and widths for the I/O bus arbiter.
package ioarb_pkg;
  localparam int IOARB_ADDR_W = 16;
  localparam int IOARB_DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } ioarb_state_t;
endpackage

// File: rtl/ioarb_rr_pick.sv
// Round-robin priority encoder: first asserted req searching upward from last_i+1,
// wrapping modulo NUM_REQ. Pure combinational.
module ioarb_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int LW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [LW-1:0]      last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               found_o
);
  localparam logic [LW:0] ONE = (LW+1)'(1);

  logic [LW:0]          sh;
  logic [NUM_REQ-1:0]   rot, rot_pick;
  logic                 hit;

  // Rotate so the search start lands on bit 0, pick the lowest set bit, rotate back.
  assign sh  = {1'b0, last_i} + ONE;
  assign rot = NUM_REQ'({req_i, req_i} >> sh);

  always_comb begin
    rot_pick = '0;
    hit      = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!hit && rot[j]) begin
        rot_pick[j] = 1'b1;
        hit         = 1'b1;
      end
    end
  end

  assign pick_o  = NUM_REQ'(({rot_pick, rot_pick} << sh) >> NUM_REQ);
  assign found_o = |req_i;
endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the iosystem access port between NUM_REQ masters.
// Optional IOARB_LOCK_EN adds a lock input that suppresses the burst-cap handover.
module io_bus_arbiter
  import ioarb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req,
  input  logic [NUM_REQ-1:0]                       we,
  input  logic [NUM_REQ-1:0][IOARB_ADDR_W-1:0]     addr,
  input  logic [NUM_REQ-1:0][IOARB_DATA_W-1:0]     wdata,
  input  logic [NUM_REQ-1:0][1:0]                  ben,
  output logic [NUM_REQ-1:0]                       ack,
  output logic [NUM_REQ-1:0]                       grant,
  output logic [NUM_REQ-1:0]                       rvalid,
  output logic [IOARB_DATA_W-1:0]                  rdata,
  output logic [IOARB_ADDR_W-1:0]                  dread_addr,
  output logic [IOARB_ADDR_W-1:0]                  dwrite_addr,
  output logic [IOARB_DATA_W-1:0]                  dwrite_data,
  output logic [1:0]                               dwrite_en,
  input  logic [IOARB_DATA_W-1:0]                  dread_data
`ifdef IOARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]                       lock
`endif
);
  localparam int LW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST+1);
  localparam logic [BW-1:0] CAP = BW'(MAX_BURST-1);

  ioarb_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [LW-1:0]      last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [LW-1:0]      owner_idx, pick_base;
  logic [NUM_REQ-1:0] pick_req, pick;
  logic               found, owned, own_req, lock_hold;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) owner_idx = LW'(i);
  end

  assign owned   = (state_q == OWNED);
  assign own_req = |(req & grant_q);

`ifdef IOARB_LOCK_EN
  assign lock_hold = |(lock & req & grant_q);
`else
  assign lock_hold = 1'b0;
`endif

  // While owned, the search excludes the owner and starts just past it.
  assign pick_req  = owned ? (req & ~grant_q) : req;
  assign pick_base = owned ? owner_idx : last_q;

  ioarb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (pick_req),
    .last_i  (pick_base),
    .pick_o  (pick),
    .found_o (found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          grant_d = pick;
          burst_d = '0;
        end
      end
      OWNED: begin
        if (!own_req) begin
          last_d  = owner_idx;
          burst_d = '0;
          if (found) begin
            grant_d = pick;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (found && burst_q == CAP && !lock_hold) begin
          grant_d = pick;
          last_d  = owner_idx;
          burst_d = '0;
        end else if (burst_q != CAP) begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= LW'(NUM_REQ-1);
      burst_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      rvalid_q <= ack & ~we;
    end
  end

  assign ack    = req & grant_q;
  assign grant  = grant_q;
  assign rvalid = rvalid_q;
  // iosystem registers dread_data itself, so it is already current in the rvalid cycle.
  assign rdata  = (|rvalid_q) ? dread_data : '0;

  always_comb begin
    dread_addr  = '0;
    dwrite_addr = '0;
    dwrite_data = '0;
    dwrite_en   = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack[i]) begin
        dread_addr  = addr[i];
        dwrite_addr = addr[i];
        dwrite_data = wdata[i];
        dwrite_en   = we[i] ? ben[i] : 2'b00;
      end
    end
  end
endmodule
